// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the RAM access arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WR_RECOVER = 3'd2,
    READ       = 3'd3,
    RD_RESP    = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_rr_select.sv
// Round-robin pick between the record (write) and playback (read) requesters.
module mem_arb_rr_select
  import mem_arb_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = wr_req | rd_req;
    grant_sel   = GRANT_WRITE;
    if (wr_req && rd_req) begin
      grant_sel = (last_grant == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
    end else if (rd_req) begin
      grant_sel = GRANT_READ;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one external RAM port between write and read requesters, one transaction at a time.
// Optional read-ack timeout is built when MEM_ARB_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | sample requests, grant one
// WRITE      | write strobe and wr_ack active for one cycle
// WR_RECOVER | forced idle gap after a write pulse
// READ       | read request held until RAM ack (or timeout)
// RD_RESP    | rd_ack pulse with captured data
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int WR_GAP = 2
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_request,
  input  logic              mem_read_ack,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [3:0] GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

  state_t              state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic                busy_q, busy_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_rr_q, mem_rr_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                grant_valid, grant_sel;
  logic                timeout_hit;

  mem_arb_rr_select u_rr_select (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rd_err_q, rd_err_d;

  // Terminal compare one below the limit so rd_ack follows exactly TIMEOUT_CYCLES READ cycles.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = '0;
    rd_err_d   = 1'b0;
    if (state_q == READ) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      rd_err_d   = timeout_hit && !mem_read_ack;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rd_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_READ;
      busy_q        <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      rd_data_q     <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      mem_rr_q      <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      busy_q        <= busy_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      rd_data_q     <= rd_data_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      mem_rr_q      <= mem_rr_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = (grant_sel == GRANT_WRITE) ? WRITE : READ;
          // Pointer only moves on contention so the first contention after reset favours write.
          if (wr_req && rd_req) last_grant_d = grant_t'(grant_sel);
        end
      end
      WRITE:      state_d = (WR_GAP == 0) ? IDLE : WR_RECOVER;
      WR_RECOVER: if (gap_cnt_q == 4'd0) state_d = IDLE;
      READ:       if (mem_read_ack || timeout_hit) state_d = RD_RESP;
      RD_RESP:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d        = (state_d != IDLE);
    wr_ack_d      = 1'b0;
    rd_ack_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_rr_d      = 1'b0;
    rd_data_d     = rd_data_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (grant_sel == GRANT_WRITE) begin
            mem_address_d = wr_addr;
            mem_data_in_d = wr_data;
            mem_we_d      = 1'b1;
            wr_ack_d      = 1'b1;
          end else begin
            mem_address_d = rd_addr;
            mem_rr_d      = 1'b1;
          end
        end
      end
      WRITE:      gap_cnt_d = GAP_LOAD;
      WR_RECOVER: if (gap_cnt_q != 4'd0) gap_cnt_d = gap_cnt_q - 4'd1;
      READ: begin
        if (mem_read_ack) begin
          rd_data_d = mem_read_data;
          rd_ack_d  = 1'b1;
        end else if (timeout_hit) begin
          rd_data_d = '0;
          rd_ack_d  = 1'b1;
        end else begin
          mem_rr_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy             = busy_q;
  assign wr_ack           = wr_ack_q;
  assign rd_ack           = rd_ack_q;
  assign rd_data          = rd_data_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_request = mem_rr_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter; timeout cases build when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_access_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_err;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_enable, mem_read_request;
  logic          mem_read_ack;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t exp_q[$];

  int            n_checks   = 0;
  int            n_fail     = 0;
  int            cyc        = 0;
  int            ack_cnt    = 0;
  int            rd_ack_cnt = 0;
  int            ram_lat    = -1;
  int            req_cnt    = 0;
  logic [DW-1:0] ram_data   = '0;
  bit            late_pulse = 1'b0;

  mem_access_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .WR_GAP (2)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ack           (wr_ack),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_ack           (rd_ack),
    .rd_data          (rd_data),
    .rd_err           (rd_err),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_read_request (mem_read_request),
    .mem_read_ack     (mem_read_ack),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_rd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit err);
    exp_t e;
    e.is_rd = is_rd;
    e.addr  = addr;
    e.data  = data;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // RAM model: acks ram_lat cycles after mem_read_request rises (ram_lat < 0: never).
  initial begin
    mem_read_ack  = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_read_request) req_cnt++;
      else req_cnt = 0;
      mem_read_ack  = late_pulse || (ram_lat >= 0 && req_cnt == ram_lat + 1);
      mem_read_data = mem_read_ack ? ram_data : 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (mem_write_enable || mem_read_request)
        check_eq("strobe_excl", 32'(mem_write_enable & mem_read_request), 32'd0);
      if (wr_ack || rd_ack) begin
        ack_cnt++;
        if (rd_ack) rd_ack_cnt++;
        check_eq("ack_excl", 32'(wr_ack & rd_ack), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ack", 32'({wr_ack, rd_ack}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("ack_kind", 32'(rd_ack), 32'(e.is_rd));
          check_eq("ack_addr", 32'(mem_address), 32'(e.addr));
          if (wr_ack) begin
            check_eq("wr_data", 32'(mem_data_in), 32'(e.data));
            check_eq("wr_strobe", 32'(mem_write_enable), 32'd1);
          end else begin
            check_eq("rd_data", 32'(rd_data), 32'(e.data));
            check_eq("rd_err", 32'(rd_err), 32'(e.err));
            check_eq("rd_req_low", 32'(mem_read_request), 32'd0);
          end
        end
      end
    end
  end

  task automatic wait_rd_req(input string tag);
    for (int i = 0; i < 20 && !mem_read_request; i++) step();
    check_eq(tag, 32'(mem_read_request), 32'd1);
  endtask

  task automatic wait_rd_ack(input string tag);
    for (int i = 0; i < 50 && !rd_ack; i++) step();
    check_eq(tag, 32'(rd_ack), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int cnt0;
    bit err_seen;
    reset   = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'({wr_ack, rd_ack, rd_err, mem_write_enable, mem_read_request, busy}), 32'd0);
    check_eq("rst_addr", 32'(mem_address), 32'd0);
    check_eq("rst_wdata", 32'(mem_data_in), 32'd0);
    check_eq("rst_rdata", 32'(rd_data), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Contention straight after reset: W,R,W,R.
    wr_addr  = 26'h00000AA;
    wr_data  = 16'h1111;
    rd_addr  = 26'h00000BB;
    ram_lat  = 1;
    ram_data = 16'h2222;
    push_exp(1'b0, 26'h00000AA, 16'h1111, 1'b0);
    push_exp(1'b1, 26'h00000BB, 16'h2222, 1'b0);
    push_exp(1'b0, 26'h00000AA, 16'h1111, 1'b0);
    push_exp(1'b1, 26'h00000BB, 16'h2222, 1'b0);
    cnt0   = ack_cnt;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 100 && (ack_cnt - cnt0) < 4; i++) step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    check_eq("cont_acks", 32'(ack_cnt - cnt0), 32'd4);
    repeat (3) step();
    check_eq("cont_drain", 32'(exp_q.size()), 32'd0);

    // Single write with WR_GAP=2.
    wr_addr = 26'h0000123;
    wr_data = 16'hBEEF;
    push_exp(1'b0, 26'h0000123, 16'hBEEF, 1'b0);
    wr_req  = 1'b1;
    check_eq("wr_busy_pre", 32'(busy), 32'd0);
    step();
    check_eq("wr_pulse", 32'({busy, mem_write_enable, wr_ack}), 32'h7);
    step();
    check_eq("wr_pulse_end", 32'({busy, mem_write_enable, wr_ack}), 32'h4);
    wr_req = 1'b0;
    step();
    check_eq("wr_gap2", 32'(busy), 32'd1);
    step();
    check_eq("wr_idle", 32'(busy), 32'd0);

    // Single read, RAM acks 4 cycles after request.
    rd_addr  = 26'h3FFFFFF;
    ram_lat  = 4;
    ram_data = 16'h1234;
    push_exp(1'b1, 26'h3FFFFFF, 16'h1234, 1'b0);
    rd_req   = 1'b1;
    wait_rd_req("rd_req_rise");
    t0 = cyc;
    check_eq("rd_addr_out", 32'(mem_address), 32'h3FFFFFF);
    wait_rd_ack("rd_ack_seen");
    check_eq("rd_latency", 32'(cyc - t0), 32'd5);
    rd_req = 1'b0;
    check_eq("wdata_hold", 32'(mem_data_in), 32'hBEEF);

    // Minimum latency: ack in the first READ cycle.
    step();
    rd_addr  = 26'h0000456;
    ram_lat  = 0;
    ram_data = 16'hCAFE;
    push_exp(1'b1, 26'h0000456, 16'hCAFE, 1'b0);
    rd_req   = 1'b1;
    t0       = cyc;
    wait_rd_ack("rd_min_seen");
    check_eq("rd_min_latency", 32'(cyc - t0), 32'd2);
    rd_req = 1'b0;

    // Stray RAM ack while idle is ignored.
    step();
    step();
    cnt0       = rd_ack_cnt;
    late_pulse = 1'b1;
    step();
    late_pulse = 1'b0;
    repeat (3) step();
    check_eq("idle_ack_ignored", 32'(rd_ack_cnt - cnt0), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a read, then fresh re-grant.
    rd_addr = 26'h1555555;
    ram_lat = -1;
    push_exp(1'b1, 26'h1555555, 16'h0000, 1'b0);
    rd_req  = 1'b1;
    wait_rd_req("rst_rd_rise");
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", 32'({wr_ack, rd_ack, rd_err, mem_write_enable, mem_read_request, busy}), 32'd0);
    check_eq("rst_mid_addr", 32'(mem_address), 32'd0);
    check_eq("rst_mid_wdata", 32'(mem_data_in), 32'd0);
    exp_q.delete();
    ram_lat  = 2;
    ram_data = 16'h5A5A;
    push_exp(1'b1, 26'h1555555, 16'h5A5A, 1'b0);
    step();
    reset = 1'b1;
    check_eq("rst_rel_idle", 32'(busy), 32'd0);
    wait_rd_ack("rst_regrant");
    rd_req = 1'b0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    rd_addr = 26'h0000777;
    ram_lat = -1;
    push_exp(1'b1, 26'h0000777, 16'h0000, 1'b1);
    rd_req  = 1'b1;
    wait_rd_req("to_rise");
    t0 = cyc;
    wait_rd_ack("to_ack_seen");
    check_eq("to_cycles", 32'(cyc - t0), 32'd8);
    rd_req = 1'b0;
    cnt0   = rd_ack_cnt;
    step();
    step();
    late_pulse = 1'b1;
    step();
    late_pulse = 1'b0;
    repeat (5) step();
    check_eq("to_late_ack", 32'(rd_ack_cnt - cnt0), 32'd0);

    // Ack landing in the expiry cycle wins.
    ram_lat  = 7;
    ram_data = 16'h7777;
    push_exp(1'b1, 26'h0000777, 16'h7777, 1'b0);
    rd_req   = 1'b1;
    wait_rd_req("race_rise");
    t0 = cyc;
    wait_rd_ack("race_ack_seen");
    check_eq("race_cycles", 32'(cyc - t0), 32'd8);
    rd_req = 1'b0;
    step();
`else
    rd_addr  = 26'h0000777;
    ram_lat  = -1;
    rd_req   = 1'b1;
    cnt0     = rd_ack_cnt;
    err_seen = 1'b0;
    repeat (100) begin
      step();
      err_seen = err_seen | rd_err;
    end
    check_eq("nto_no_ack", 32'(rd_ack_cnt - cnt0), 32'd0);
    check_eq("nto_err_low", 32'(err_seen), 32'd0);
    check_eq("nto_waiting", 32'({busy, mem_read_request}), 32'h3);
    reset  = 1'b0;
    rd_req = 1'b0;
    step();
    reset  = 1'b1;
`endif

    repeat (3) step();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
